// File: rtl/lane_assist.sv
// Lane-keeping assist controller: turns lane-drift sensor requests into a
// registered 3-bit steering-correction code, escalating NUDGE to STEER
// when the same drift request persists.
module lane_assist #(
  parameter int unsigned ESC_CYCLES = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       assist_right,
  input  logic       assist_left,
  input  logic       assist_disable,
  output logic [2:0] lane
);

  // State encodings match the lane code each state drives.
  localparam logic [2:0] ST_CENTER   = 3'b010;
  localparam logic [2:0] ST_NUDGE_L  = 3'b110;
  localparam logic [2:0] ST_STEER_L  = 3'b100;
  localparam logic [2:0] ST_NUDGE_R  = 3'b011;
  localparam logic [2:0] ST_STEER_R  = 3'b001;
  localparam logic [2:0] ST_DISABLED = 3'b000;
  localparam logic [2:0] ST_CONFLICT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ESC_LAST = CNT_W'(ESC_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       lane_nxt;
  logic             state_legal;
  logic             req_r_only;
  logic             req_l_only;

  // Flag encodings outside the seven defined states.
  always_comb begin
    state_legal = 1'b1;
    if (state == 3'b101) state_legal = 1'b0;
  end

  // Decode the single-direction requests.
  always_comb begin
    req_r_only = assist_right & ~assist_left;
    req_l_only = assist_left & ~assist_right;
  end

  // Next-state and escalation counter, disable > conflict > drift > idle.
  always_comb begin
    state_nxt = ST_CENTER;
    cnt_nxt   = CNT_ZERO;
    if (!state_legal) begin
      state_nxt = ST_CENTER;
      cnt_nxt   = CNT_ZERO;
    end else if (assist_disable) begin
      state_nxt = ST_DISABLED;
      cnt_nxt   = CNT_ZERO;
    end else if (assist_right && assist_left) begin
      state_nxt = ST_CONFLICT;
      cnt_nxt   = CNT_ZERO;
    end else if (req_r_only) begin
      case (state)
        ST_NUDGE_L: begin
          if (cnt == ESC_LAST) begin
            state_nxt = ST_STEER_L;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = ST_NUDGE_L;
            cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          end
        end
        ST_STEER_L: begin
          state_nxt = ST_STEER_L;
          cnt_nxt   = CNT_ZERO;
        end
        default: begin
          state_nxt = ST_NUDGE_L;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else if (req_l_only) begin
      case (state)
        ST_NUDGE_R: begin
          if (cnt == ESC_LAST) begin
            state_nxt = ST_STEER_R;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = ST_NUDGE_R;
            cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          end
        end
        ST_STEER_R: begin
          state_nxt = ST_STEER_R;
          cnt_nxt   = CNT_ZERO;
        end
        default: begin
          state_nxt = ST_NUDGE_R;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt = ST_CENTER;
      cnt_nxt   = CNT_ZERO;
    end
  end

  // Decode the upcoming state into its lane code so lane is registered.
  always_comb begin
    lane_nxt = 3'b010;
    case (state_nxt)
      ST_CENTER:   lane_nxt = 3'b010;
      ST_NUDGE_L:  lane_nxt = 3'b110;
      ST_STEER_L:  lane_nxt = 3'b100;
      ST_NUDGE_R:  lane_nxt = 3'b011;
      ST_STEER_R:  lane_nxt = 3'b001;
      ST_DISABLED: lane_nxt = 3'b000;
      ST_CONFLICT: lane_nxt = 3'b111;
      default:     lane_nxt = 3'b010;
    endcase
  end

  // State, counter and lane registers; reset returns to CENTER at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_CENTER;
      cnt   <= CNT_ZERO;
      lane  <= 3'b010;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lane  <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_lane_assist.sv
// Bench for lane_assist: directed scenarios with literal expectations plus
// randomized drift requests, checked against a run-length model on three
// instances with different escalation thresholds.
module tb_lane_assist;

  localparam int REQ_NONE = 0;
  localparam int REQ_R    = 1;
  localparam int REQ_L    = 2;
  localparam int REQ_CONF = 3;
  localparam int REQ_DIS  = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ar, al, ad;
  logic [2:0] lane_e2, lane_e1, lane_e4;

  int n_cmp = 0;
  int n_bad = 0;
  int last_req;
  int run_len;

  always #5 CLK = ~CLK;

  lane_assist #(.ESC_CYCLES(2), .CNT_W(8)) dut_e2 (
    .CLK(CLK), .RST(RST), .assist_right(ar), .assist_left(al),
    .assist_disable(ad), .lane(lane_e2));
  lane_assist #(.ESC_CYCLES(1), .CNT_W(8)) dut_e1 (
    .CLK(CLK), .RST(RST), .assist_right(ar), .assist_left(al),
    .assist_disable(ad), .lane(lane_e1));
  lane_assist #(.ESC_CYCLES(4), .CNT_W(8)) dut_e4 (
    .CLK(CLK), .RST(RST), .assist_right(ar), .assist_left(al),
    .assist_disable(ad), .lane(lane_e4));

  // Expected lane: a drift request held for run_len edges steers once the
  // run exceeds the escalation threshold.
  function automatic logic [2:0] model_lane(int esc);
    case (last_req)
      REQ_DIS:  return 3'b000;
      REQ_CONF: return 3'b111;
      REQ_R:    return (run_len <= esc) ? 3'b110 : 3'b100;
      REQ_L:    return (run_len <= esc) ? 3'b011 : 3'b001;
      default:  return 3'b010;
    endcase
  endfunction

  task automatic model_reset();
    last_req = REQ_NONE;
    run_len  = 0;
  endtask

  task automatic model_edge();
    int req;
    if (ad)            req = REQ_DIS;
    else if (ar && al) req = REQ_CONF;
    else if (ar)       req = REQ_R;
    else if (al)       req = REQ_L;
    else               req = REQ_NONE;
    if (req == last_req && (req == REQ_R || req == REQ_L))
      run_len = (run_len < 100000) ? run_len + 1 : run_len;
    else
      run_len = 1;
    last_req = req;
  endtask

  task automatic check(string nm, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: lane=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_all(string nm);
    check({nm, "/esc2"}, lane_e2, model_lane(2));
    check({nm, "/esc1"}, lane_e1, model_lane(1));
    check({nm, "/esc4"}, lane_e4, model_lane(4));
  endtask

  // Apply inputs, take one rising edge, then compare all instances.
  task automatic tick(logic r, logic l, logic d, string nm);
    ar = r; al = l; ad = d;
    @(posedge CLK);
    #1;
    model_edge();
    cmp_all(nm);
  endtask

  // Pulse reset between edges and confirm CENTER appears without a clock.
  task automatic async_reset(string nm);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check({nm, "/lit"}, lane_e2, 3'b010);
    cmp_all(nm);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ar = 1'b0; al = 1'b0; ad = 1'b0;
    model_reset();
    #1;
    check("reset_async_lit", lane_e2, 3'b010);
    cmp_all("reset_async");
    #2;
    RST = 1'b0;

    tick(0, 0, 0, "idle1"); check("idle1_lit", lane_e2, 3'b010);
    tick(0, 0, 0, "idle2"); check("idle2_lit", lane_e2, 3'b010);

    tick(1, 0, 0, "right1"); check("right1_lit", lane_e2, 3'b110);
    check("esc1_right1_lit", lane_e1, 3'b110);
    tick(1, 0, 0, "right2"); check("right2_lit", lane_e2, 3'b110);
    check("esc1_right2_lit", lane_e1, 3'b100);
    tick(1, 0, 0, "right3"); check("right3_lit", lane_e2, 3'b100);
    tick(1, 0, 0, "right4"); check("right4_lit", lane_e2, 3'b100);
    tick(0, 0, 0, "right_drop"); check("right_drop_lit", lane_e2, 3'b010);

    tick(0, 1, 0, "left1"); check("left1_lit", lane_e2, 3'b011);
    tick(0, 1, 0, "left2"); check("left2_lit", lane_e2, 3'b011);
    tick(0, 1, 0, "left3"); check("left3_lit", lane_e2, 3'b001);
    async_reset("left_reset");
    tick(0, 1, 0, "left_after_reset"); check("left_after_reset_lit", lane_e2, 3'b011);

    tick(1, 0, 1, "dis1"); check("dis1_lit", lane_e2, 3'b000);
    tick(1, 0, 1, "dis2"); check("dis2_lit", lane_e2, 3'b000);
    tick(1, 0, 0, "dis_release"); check("dis_release_lit", lane_e2, 3'b110);

    tick(1, 1, 0, "conflict"); check("conflict_lit", lane_e2, 3'b111);
    tick(0, 1, 0, "rev_left"); check("rev_left_lit", lane_e2, 3'b011);
    tick(1, 0, 0, "rev_right"); check("rev_right_lit", lane_e2, 3'b110);
    tick(1, 0, 0, "rev_right2");
    tick(1, 0, 0, "rev_right3"); check("rev_right3_lit", lane_e2, 3'b100);
    tick(0, 1, 0, "rev_from_steer"); check("rev_from_steer_lit", lane_e2, 3'b011);

    // Randomized drift: inputs tend to persist so escalation is exercised.
    for (int i = 0; i < 800; i++) begin
      logic r, l, d;
      r = ar; l = al; d = ad;
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(5))
          0: begin r = 1'b0; l = 1'b0; end
          1, 2: begin r = 1'b1; l = 1'b0; end
          3, 4: begin r = 1'b0; l = 1'b1; end
          default: begin r = 1'b1; l = 1'b1; end
        endcase
        d = ($urandom_range(7) == 0);
      end
      tick(r, l, d, "rand");
      if ($urandom_range(63) == 0) async_reset("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
